// File: rtl/bounce_emulator_if.sv
// Request/response bundle for bounce_emulator: requester drives req_*,
// the emulator returns handshake status and the emulated button pin.
interface bounce_emulator_if;
    logic req_valid;
    logic req_level;
    logic req_ready;
    logic pulsador_o;
    logic busy;
    logic done;

    modport master (
        output req_valid, req_level,
        input  req_ready, pulsador_o, busy, done
    );

    modport slave (
        input  req_valid, req_level,
        output req_ready, pulsador_o, busy, done
    );
endinterface

// File: rtl/bounce_emulator.sv
// Pushbutton emulator: on request drives a bouncy burst that settles to the requested level.
// Define BOUNCE_FIXED_EN for fixed GLITCH_MIN_CYC phases (no LFSR); default uses LFSR phase lengths.
module bounce_emulator #(
    parameter int unsigned CLK_FREQ_HZ    = 27_000_000,
    parameter int unsigned BOUNCE_COUNT   = 6,
    parameter int unsigned GLITCH_MIN_CYC = 2700,
    parameter logic [15:0] GLITCH_MASK    = 16'h1FFF,
    parameter int unsigned SETTLE_CYC     = 54000,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input logic clk,
    input logic rst,
    bounce_emulator_if.slave bus
);

    localparam int unsigned PHASE_MAX = GLITCH_MIN_CYC + 32'(GLITCH_MASK);
    localparam int unsigned CYC_MAX   = (PHASE_MAX > SETTLE_CYC) ? PHASE_MAX : SETTLE_CYC;
    localparam int unsigned CNT_W     = $clog2(CYC_MAX) + 1;
    localparam int unsigned K_W       = $clog2(BOUNCE_COUNT + 1) + 1;

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] MIN_LOAD    = CNT_W'(GLITCH_MIN_CYC - 1);
    localparam logic [K_W-1:0]   LAST_K      = K_W'(BOUNCE_COUNT - 1);

    if (GLITCH_MIN_CYC < 1 || SETTLE_CYC < 1 || LFSR_SEED == 16'h0 || CLK_FREQ_HZ == 0) begin : g_bad_params
        $error("bounce_emulator: invalid parameter set");
    end

    typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

    state_t           state;
    logic             pin;
    logic             target;
    logic             ready;
    logic             active;
    logic             fin;
    logic [CNT_W-1:0] cnt;
    logic [K_W-1:0]   k;
    logic [CNT_W-1:0] phase_load;

`ifdef BOUNCE_FIXED_EN
    assign phase_load = MIN_LOAD;
`else
    logic [15:0] lfsr;

    // Galois form, taps x^16+x^14+x^13+x^11+1, shifting right
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    assign phase_load = MIN_LOAD + CNT_W'(lfsr & GLITCH_MASK);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            pin    <= 1'b0;
            target <= 1'b0;
            ready  <= 1'b1;
            active <= 1'b0;
            fin    <= 1'b0;
            cnt    <= '0;
            k      <= '0;
`ifndef BOUNCE_FIXED_EN
            lfsr   <= LFSR_SEED;
`endif
        end else begin
            fin <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid && ready) begin
                        target <= bus.req_level;
                        ready  <= 1'b0;
                        active <= 1'b1;
                        pin    <= bus.req_level;
                        if (BOUNCE_COUNT != 0 && bus.req_level != pin) begin
                            state <= BOUNCE;
                            cnt   <= phase_load;
                            k     <= '0;
`ifndef BOUNCE_FIXED_EN
                            lfsr  <= lfsr_next(lfsr);
`endif
                        end else begin
                            state <= SETTLE;
                            cnt   <= SETTLE_LOAD;
                        end
                    end
                end
                BOUNCE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (k == LAST_K) begin
                        state <= SETTLE;
                        pin   <= target;
                        cnt   <= SETTLE_LOAD;
                    end else begin
                        // Alternating phases: even k drives target, odd k its complement
                        k   <= k + K_W'(1);
                        pin <= ~pin;
                        cnt <= phase_load;
`ifndef BOUNCE_FIXED_EN
                        lfsr <= lfsr_next(lfsr);
`endif
                    end
                end
                SETTLE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state  <= IDLE;
                        fin    <= 1'b1;
                        active <= 1'b0;
                        ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = ready;
    assign bus.pulsador_o = pin;
    assign bus.busy       = active;
    assign bus.done       = fin;

endmodule

// File: doc/bounce_emulator.md
Name: bounce_emulator

Overview:
- Synthesizable pushbutton emulator; the transmit-side counterpart of the board's debounce/LED-counter path.
- On request, drives a `pulsador`-style pin with a bursty, bouncy transition that settles to a requested level.
- Used on-FPGA for hardware-in-loop self-test of the debouncer, with no physical button.
- Bounce phase lengths come from an LFSR, so every burst differs but is reproducible from the seed.

Parameters:
- CLK_FREQ_HZ, 27_000_000: system clock; documentation and derived defaults only.
- BOUNCE_COUNT, 6: number of bounce phases before settling; 0 gives a clean edge.
- GLITCH_MIN_CYC, 2700: minimum phase length in cycles (100 us at 27 MHz); must be >= 1.
- GLITCH_MASK, 16'h1FFF: mask applied to the LFSR to form the random extra phase length.
- SETTLE_CYC, 54000: cycles the output is held stable at target before done (2 ms).
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock, 27 MHz
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request a transition
- req_level  in  1  target level, 1 = press, 0 = release
- req_ready  out  1  high only in IDLE
- pulsador_o  out  1  emulated button pin, registered
- busy  out  1  high in BOUNCE and SETTLE
- done  out  1  one-cycle pulse when settle completes

Behaviour:
- Reset (rst = 0, asynchronous):
  - pulsador_o = 0, req_ready = 1, busy = 0, done = 0.
  - LFSR = LFSR_SEED; state = IDLE.
  - Applies immediately mid-burst; the output drops to 0 without finishing the burst.
- Handshake:
  - Accept on the rising edge where req_valid & req_ready.
  - req_level is latched into `target`; later changes to req_level are ignored.
  - req_valid while busy is ignored, not queued.
- IDLE:
  - pulsador_o holds its last value.
  - On accept with BOUNCE_COUNT > 0 and target != pulsador_o, go to BOUNCE with phase index k = 0.
  - On accept with BOUNCE_COUNT == 0, or with target == pulsador_o, go directly to SETTLE with pulsador_o = target. No glitches are produced.
- BOUNCE:
  - Phase k drives pulsador_o = target when k is even, ~target when k is odd.
  - Phase length D = GLITCH_MIN_CYC + (lfsr & GLITCH_MASK), sampled when the phase starts.
  - The LFSR advances exactly once per phase start and never otherwise.
  - pulsador_o changes in the cycle after accept; latency is 1 cycle.
  - After phase BOUNCE_COUNT-1 has run D cycles, go to SETTLE.
- SETTLE:
  - pulsador_o = target for exactly SETTLE_CYC cycles.
  - Then done = 1 for one cycle and the next state is IDLE, with req_ready = 1 in that same cycle.
  - A new request may be accepted on the edge after done.
- LFSR:
  - 16-bit Galois, taps 0xB400 (x^16+x^14+x^13+x^11+1), shifting right.
  - A zero state is unreachable because the seed is nonzero.
- Widths:
  - Phase and settle counters are sized with $clog2 of the maximum of (GLITCH_MIN_CYC + GLITCH_MASK) and SETTLE_CYC, plus one bit.
  - The addition is unsigned with no overflow.
- Invariant: pulsador_o never changes outside BOUNCE, or on entry to SETTLE/BOUNCE.

Optional Feature:
- Macro: BOUNCE_FIXED_EN.
- Defined:
  - D = GLITCH_MIN_CYC for every phase; the LFSR is not instantiated.
  - Bursts are fully deterministic, for directed tests and scope captures.
- Undefined: phase lengths come from the LFSR, as in Behaviour.

Test Plan:
- Reset values: hold rst = 0 for 10 cycles, then release.
  - Response: pulsador_o = 0, req_ready = 1, busy = 0, done = 0. A 1-cycle req_valid with req_level = 1 is accepted on the next edge.
- Fixed-timing press, with BOUNCE_FIXED_EN, GLITCH_MIN_CYC = 4, BOUNCE_COUNT = 5, SETTLE_CYC = 20, accept at edge N:
  - pulsador_o is 1,0,1,0,1 in 4-cycle blocks over cycles N+1..N+20.
  - pulsador_o is 1 over N+21..N+40.
  - done is high only at N+41; busy is high for cycles N+1..N+40.
- Random release (LFSR build), GLITCH_MIN_CYC = 4, GLITCH_MASK = 3, BOUNCE_COUNT = 6, after the press from the previous test:
  - The bench model of the LFSR predicts each phase length in 4..7.
  - pulsador_o matches the model cycle-exactly and ends at 0.
  - Two runs from the same seed are identical.
- Same-level and ignored requests:
  - req_level = 1 while pulsador_o = 1 gives no glitch, and done after SETTLE_CYC + 1 cycles.
  - req_valid asserted mid-BOUNCE is ignored; it gives no extra done and no change in phase sequence.
- Reset mid-burst: assert rst = 0 during phase 2 with pulsador_o = 1.
  - Response: pulsador_o = 0 asynchronously, and the LFSR returns to 16'hACE1.
  - After release, the next burst reproduces the first burst after reset.
- Integration with the debounce/LED top: drive the top's `pulsador` from pulsador_o for 3 press/release pairs.
  - Required result: leds increments by exactly 1 per press, ending at 8'd3.
